ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable reporting) to a keyboard/mouse.
//  Complements the existing device-to-host PS/2 receivers; shares the PS2C/PS2D open-drain lines with them.
//  Lines are open-drain: *_oe=1 drives the line low, *_oe=0 releases it (pull-up). Sits beside the kbd/mouse receivers in the top level.
// PARAMETERS
//  INHIBIT_CYC  2500    clk cycles PS2C is held low before request (100 us @ 25 MHz)
//  TIMEOUT_CYC  375000  max clk cycles between device clock falling edges, and for the final release, before abort (15 ms)
// PORTS
//  clk      in   1  system clock (25 MHz)
//  rst      in   1  synchronous reset, active-high
//  start    in   1  one-cycle request; accepted only when rdy=1
//  data     in   8  command byte, captured on accepted start
//  rdy      out  1  1 = idle, may accept start
//  done     out  1  one-cycle pulse at end of transfer (success, NACK or timeout)
//  nack     out  1  valid with done: 1 = device did not drive ACK low
//  tmo      out  1  valid with done: 1 = aborted on timeout
//  ps2c_in  in   1  raw PS2C line level (asynchronous)
//  ps2d_in  in   1  raw PS2D line level (asynchronous)
//  ps2c_oe  out  1  1 = pull PS2C low
//  ps2d_oe  out  1  1 = pull PS2D low
// BEHAVIOUR
//  - Reset: state IDLE; rdy=1, done=0, nack=0, tmo=0, ps2c_oe=0, ps2d_oe=0; counters cleared. Reset mid-frame releases both lines next cycle.
//  - ps2c_in/ps2d_in pass through 2-FF synchronisers. fall = sync PS2C was 1 last cycle and is 0 now (single-cycle strobe).
//  - start accepted when rdy=1: shift reg <= {1'b1 stop, ~^data odd parity, data}. rdy drops the next cycle. start with rdy=0 is ignored.
//  - States:
//    IDLE:    oe both 0. On start -> INHIBIT, cnt=0.
//    INHIBIT: ps2c_oe=1, ps2d_oe=0. When cnt==INHIBIT_CYC-1 -> REQ.
//    REQ:     1 cycle: ps2d_oe=1 (start bit 0), ps2c_oe=0. -> SEND, bitcnt=0, tmo cnt=0.
//    SEND:    on each fall: drive bit[bitcnt] (ps2d_oe = ~bit), bitcnt++. Falls 1..8 = data LSB first, 9 = parity, 10 = stop (ps2d_oe=0).
//             After fall 10 -> ACK.
//    ACK:     on next fall (11th) sample sync PS2D: 0 -> nack_r=0, 1 -> nack_r=1. -> WREL.
//    WREL:    wait until sync PS2C=1 and sync PS2D=1 -> DONE.
//    DONE:    1 cycle: done=1, nack=nack_r, tmo=0. -> IDLE (rdy=1 next cycle).
//  - Timeout: in SEND/ACK the counter resets on every fall; in WREL it runs from entry. At TIMEOUT_CYC -> release both lines,
//    done=1, tmo=1, nack=1 for one cycle, -> IDLE.
//  - Lines are driven only in INHIBIT/REQ/SEND; never both ps2c_oe and ps2d_oe=1 in INHIBIT.
//  - Data changes only on fall (device clock low); the device samples on the rising edge.
//  - Counter width: clog2(TIMEOUT_CYC+1); no wrap possible before abort.
// TESTING
//  1 start, data=0xED, device model clocks 11 edges and ACKs -> ps2c_oe=1 for exactly 2500 cycles;
//    bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen on PS2D; done=1, nack=0, tmo=0.
//  2 data=0x01 -> parity bit 0; data=0x00 -> parity bit 1; done with nack=0 both times.
//  3 device leaves PS2D high at 11th fall -> done=1, nack=1, tmo=0; rdy=1 the following cycle.
//  4 device stops clocking after 4 falls -> after 375000 cycles: done=1, tmo=1, nack=1, ps2c_oe=ps2d_oe=0.
//  5 start pulsed while busy (after 3 falls) with data=0x55 -> ignored; the original byte completes unchanged.
//  6 rst asserted during SEND -> next cycle ps2c_oe=ps2d_oe=0, rdy=1, done=0; a new start then sends a full frame correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain PS2C/PS2D.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2500,
  parameter int TIMEOUT_CYC = 375000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       rdy,
  output logic       done,
  output logic       nack,
  output logic       tmo,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WREL, DONE} state_t;
  state_t state, state_n;
  logic [1:0] c_s, d_s;
  logic c_q, fall, tmo_hit, abort, lines_high;
  logic [9:0] sr;
  logic [3:0] bitcnt;
  logic [CW-1:0] cnt;
  logic d_r, nack_r, tmo_r;
  assign fall = c_q & ~c_s[1];
  assign lines_high = c_s[1] & d_s[1];
  assign tmo_hit = cnt == CW'(TIMEOUT_CYC - 1);
  always_comb begin
    state_n = state;
    abort = 1'b0;
    case (state)
      IDLE: state_n = start ? INHIBIT : IDLE;
      INHIBIT: state_n = cnt == CW'(INHIBIT_CYC - 1) ? REQ : INHIBIT;
      REQ: state_n = SEND;
      SEND: begin
        abort = !fall && tmo_hit;
        state_n = (fall && bitcnt == 4'd9) ? ACK : abort ? DONE : SEND;
      end
      ACK: begin
        abort = !fall && tmo_hit;
        state_n = fall ? WREL : abort ? DONE : ACK;
      end
      WREL: begin
        abort = !lines_high && tmo_hit;
        state_n = (lines_high || abort) ? DONE : WREL;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign rdy = state == IDLE;
  assign done = state == DONE;
  assign nack = done & nack_r;
  assign tmo = done & tmo_r;
  assign ps2c_oe = state == INHIBIT;
  assign ps2d_oe = (state == REQ || state == SEND) & d_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c_s <= 2'b11;
      d_s <= 2'b11;
      c_q <= 1'b1;
      sr <= '0;
      bitcnt <= '0;
      cnt <= '0;
      d_r <= 1'b0;
      nack_r <= 1'b0;
      tmo_r <= 1'b0;
    end else begin
      state <= state_n;
      c_s <= {c_s[0], ps2c_in};
      d_s <= {d_s[0], ps2d_in};
      c_q <= c_s[1];
      // timeout window restarts on every device clock edge only while bits are moving
      cnt <= (state_n != state || state == IDLE || (fall && (state == SEND || state == ACK))) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) sr <= {1'b1, ~^data, data};
      bitcnt <= (state == REQ) ? '0 : (state == SEND && fall) ? bitcnt + 4'd1 : bitcnt;
      if (state == INHIBIT) d_r <= 1'b1;
      else if (state == SEND && fall) d_r <= ~sr[bitcnt];
      if (state == IDLE) {nack_r, tmo_r} <= 2'b00;
      else if (abort) {nack_r, tmo_r} <= 2'b11;
      else if (state == ACK && fall) nack_r <= d_s[1];
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized device-model bench for the PS/2 host transmitter.
module tb_ps2_host_tx;
  localparam int INH = 2500;
  localparam int TMO = 3000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] data = 8'h00;
  logic rdy, done, nack, tmo, ps2c_oe, ps2d_oe, ps2c_in, ps2d_in;
  logic dev_c = 1'b0, dev_d = 1'b0;
  int n_chk = 0, n_fail = 0, half = 20, dev_falls = 0;
  int done_cnt = 0, oe_run = 0, last_run = 0, both_oe = 0;
  logic last_nack, last_tmo, last_c, last_d, rdy_after, done_prev = 1'b0;

  assign ps2c_in = !(ps2c_oe || dev_c);
  assign ps2d_in = !(ps2d_oe || dev_d);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .rdy(rdy), .done(done),
    .nack(nack), .tmo(tmo), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (done_prev) rdy_after = rdy;
    if (done === 1'b1) begin
      done_cnt++;
      last_nack = nack;
      last_tmo = tmo;
      last_c = ps2c_oe;
      last_d = ps2d_oe;
    end
    done_prev = done;
    if (ps2c_oe === 1'b1) oe_run++;
    else if (oe_run > 0) begin
      last_run = oe_run;
      oe_run = 0;
    end
    if (ps2c_oe === 1'b1 && ps2d_oe === 1'b1) both_oe++;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_start(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    data = b;
    @(posedge clk); #1;
    start = 1'b0;
    data = 8'($urandom);
  endtask

  // device side: waits for the request, samples start bit and each bit on the rising edge
  task automatic dev_frame(input int nf, input bit ack, output logic [10:0] fr, output bit ok);
    int w = 0;
    ok = 1'b0;
    fr = '1;
    dev_falls = 0;
    while (w < 2 * INH + 100 && !(ps2c_oe === 1'b0 && ps2d_oe === 1'b1)) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2 * INH + 100) return;
    repeat (half) @(negedge clk);
    fr[0] = ps2d_in;
    for (int k = 1; k <= nf; k++) begin
      if (k == 11) begin
        dev_d = ack;
        repeat (half) @(negedge clk);
      end
      dev_c = 1'b1;
      dev_falls = k;
      repeat (half) @(negedge clk);
      if (k <= 10) fr[k] = ps2d_in;
      dev_c = 1'b0;
      repeat (half) @(negedge clk);
    end
    dev_d = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_done(input int n0, input int lim, output bit got, output int cyc);
    cyc = 0;
    while (done_cnt == n0 && cyc < lim) begin
      @(posedge clk);
      cyc++;
    end
    got = done_cnt != n0;
    @(posedge clk);
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack, output logic [10:0] fr, output bit ok, output bit got);
    int n0, cyc;
    n0 = done_cnt;
    rdy_after = 1'b0;
    send_start(b);
    dev_frame(11, ack, fr, ok);
    wait_done(n0, 300, got, cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk += 6;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b want=1", rdy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    if (nack !== 1'b0) begin n_fail++; $display("FAIL reset_nack got=%b want=0", nack); end
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got=%b want=0", tmo); end
    if (ps2c_oe !== 1'b0) begin n_fail++; $display("FAIL reset_c_oe got=%b want=0", ps2c_oe); end
    if (ps2d_oe !== 1'b0) begin n_fail++; $display("FAIL reset_d_oe got=%b want=0", ps2d_oe); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ed;
    logic [10:0] fr;
    bit ok, got;
    do_frame(8'hED, 1'b1, fr, ok, got);
    n_chk += 7;
    if (!ok) begin n_fail++; $display("FAIL ed_request got=none want=request"); end
    if (!got) begin n_fail++; $display("FAIL ed_done got=none want=pulse"); end
    if (fr !== frame_of(8'hED)) begin n_fail++; $display("FAIL ed_frame got=%b want=%b", fr, frame_of(8'hED)); end
    if (last_nack !== 1'b0) begin n_fail++; $display("FAIL ed_nack got=%b want=0", last_nack); end
    if (last_tmo !== 1'b0) begin n_fail++; $display("FAIL ed_tmo got=%b want=0", last_tmo); end
    if (last_run != INH) begin n_fail++; $display("FAIL ed_inhibit got=%0d want=%0d", last_run, INH); end
    if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL ed_rdy_after got=%b want=1", rdy_after); end
  endtask

  task automatic test_parity;
    logic [10:0] fr;
    bit ok, got;
    logic [7:0] v[2] = '{8'h01, 8'h00};
    logic want_par[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      do_frame(v[i], 1'b1, fr, ok, got);
      n_chk += 3;
      if (fr[9] !== want_par[i]) begin n_fail++; $display("FAIL parity_%02h got=%b want=%b", v[i], fr[9], want_par[i]); end
      if (fr !== frame_of(v[i])) begin n_fail++; $display("FAIL parity_frame_%02h got=%b want=%b", v[i], fr, frame_of(v[i])); end
      if (!got || last_nack !== 1'b0) begin n_fail++; $display("FAIL parity_done_%02h got=%b nack=%b want=1/0", v[i], got, last_nack); end
    end
  endtask

  task automatic test_nack;
    logic [10:0] fr;
    bit ok, got;
    logic [7:0] b = 8'($urandom);
    do_frame(b, 1'b0, fr, ok, got);
    n_chk += 5;
    if (!got) begin n_fail++; $display("FAIL nack_done got=none want=pulse"); end
    if (last_nack !== 1'b1) begin n_fail++; $display("FAIL nack_flag got=%b want=1", last_nack); end
    if (last_tmo !== 1'b0) begin n_fail++; $display("FAIL nack_tmo got=%b want=0", last_tmo); end
    if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL nack_rdy_after got=%b want=1", rdy_after); end
    if (fr !== frame_of(b)) begin n_fail++; $display("FAIL nack_frame got=%b want=%b", fr, frame_of(b)); end
  endtask

  task automatic test_timeout;
    logic [10:0] fr;
    bit ok, got;
    int n0, cyc;
    n0 = done_cnt;
    rdy_after = 1'b0;
    send_start(8'($urandom));
    dev_frame(4, 1'b0, fr, ok);
    wait_done(n0, TMO + 200, got, cyc);
    n_chk += 7;
    if (!got) begin n_fail++; $display("FAIL tmo_done got=none want=pulse"); end
    if (last_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got=%b want=1", last_tmo); end
    if (last_nack !== 1'b1) begin n_fail++; $display("FAIL tmo_nack got=%b want=1", last_nack); end
    if (last_c !== 1'b0 || last_d !== 1'b0) begin n_fail++; $display("FAIL tmo_lines got=%b%b want=00", last_c, last_d); end
    if (cyc < TMO - 2 * half - 10 || cyc > TMO + 10) begin n_fail++; $display("FAIL tmo_delay got=%0d want=~%0d", cyc, TMO - 2 * half); end
    if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL tmo_rdy_after got=%b want=1", rdy_after); end
    if (!ok) begin n_fail++; $display("FAIL tmo_request got=none want=request"); end
  endtask

  task automatic test_busy_start;
    logic [10:0] fr;
    bit ok, got;
    int n0, cyc, idle_ok;
    logic busy;
    logic [7:0] b = 8'($urandom);
    if (b == 8'h55) b = 8'hAA;
    n0 = done_cnt;
    dev_falls = 0;
    send_start(b);
    fork
      dev_frame(11, 1'b1, fr, ok);
      begin
        int w = 0;
        while (dev_falls < 3 && w < 20000) begin
          @(posedge clk);
          w++;
        end
        #1;
        busy = rdy;
        start = 1'b1;
        data = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done(n0, 300, got, cyc);
    idle_ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (rdy !== 1'b1) idle_ok = 0;
    end
    n_chk += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_rdy got=%b want=0", busy); end
    if (fr !== frame_of(b)) begin n_fail++; $display("FAIL busy_frame got=%b want=%b", fr, frame_of(b)); end
    if (!got) begin n_fail++; $display("FAIL busy_done got=none want=pulse"); end
    if (last_nack !== 1'b0) begin n_fail++; $display("FAIL busy_nack got=%b want=0", last_nack); end
    if (idle_ok != 1) begin n_fail++; $display("FAIL busy_idle got=restart want=idle"); end
  endtask

  task automatic test_rst_mid;
    logic [10:0] fr;
    bit ok, got;
    logic [7:0] b = 8'($urandom);
    logic busy;
    send_start(8'($urandom));
    dev_frame(4, 1'b0, fr, ok);
    #1;
    busy = rdy;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lines got=%b%b want=00", ps2c_oe, ps2d_oe); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rdy got=%b want=1", rdy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b want=0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    do_frame(b, 1'b1, fr, ok, got);
    if (!got || fr !== frame_of(b) || last_nack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_refr got=%b/%b nack=%b want=1/%b nack=0", got, fr, last_nack, frame_of(b));
    end
  endtask

  task automatic test_random;
    logic [10:0] fr;
    bit ok, got, ack;
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      ack = ($urandom % 4) != 0;
      half = $urandom_range(10, 30);
      do_frame(b, ack, fr, ok, got);
      n_chk += 3;
      if (!got) begin n_fail++; $display("FAIL rand%0d_done got=none want=pulse", i); end
      if (fr !== frame_of(b)) begin n_fail++; $display("FAIL rand%0d_frame got=%b want=%b", i, fr, frame_of(b)); end
      if (last_nack !== !ack || last_tmo !== 1'b0) begin n_fail++; $display("FAIL rand%0d_flags got=%b%b want=%b0", i, last_nack, last_tmo, !ack); end
    end
    half = 20;
  endtask

  initial begin
    test_reset;
    test_ed;
    test_parity;
    test_nack;
    test_timeout;
    test_busy_start;
    test_rst_mid;
    test_random;
    n_chk++;
    if (both_oe != 0) begin n_fail++; $display("FAIL both_oe got=%0d want=0", both_oe); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
